exmem_pipeline_ctrl: RTL and testbench

//  Parametrised fixed-latency memory for the user project area. Successor to the

---
 rtl/exmem_pipeline_ctrl.sv | 125 ++++++++++++
 tb/tb_exmem_pipeline_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_pipeline_ctrl.sv
// rtl/exmem_pipeline_ctrl.sv - fixed-latency in-order memory with outstanding-request limit
// Requests travel a non-stalling delay line; the RAM is touched one cycle before the response is registered.
module exmem_pipeline_ctrl #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 10,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stb,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic [31:0]           addr,
    input  logic [DATA_W-1:0]     dat_i,
    output logic                  stall,
    output logic                  ack,
    output logic                  err,
    output logic [DATA_W-1:0]     dat_o
);

    localparam int NB  = DATA_W / 8;
    localparam int BSH = (NB > 1) ? $clog2(NB) : 0;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(MAX_OUT + 1);
    localparam int NST = LATENCY - 1;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [NB-1:0]     sel;
        logic [31:0]       addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              stg_q [NST];
    logic              acc_valid_q;
    logic              acc_we_q;
    logic              acc_oor_q;
    logic [DATA_W-1:0] rd_q;
    logic              ack_q,  ack_d;
    logic              err_q,  err_d;
    logic [DATA_W-1:0] dat_q,  dat_d;
    logic [CW-1:0]     inflight_q, inflight_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    req_t              last;
    logic [31:0]       last_widx;
    logic              last_oor;
    logic [AW-1:0]     last_idx;

    assign stall     = (inflight_q == CW'(MAX_OUT));
    assign accept    = stb & ~stall;
    assign last      = stg_q[NST-1];
    assign last_widx = last.addr >> BSH;
    assign last_oor  = (last_widx >= 32'(DEPTH));
    assign last_idx  = last_widx[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NST; i++) begin
                stg_q[i] <= '0;
            end
            acc_valid_q <= 1'b0;
            acc_we_q    <= 1'b0;
            acc_oor_q   <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            dat_q       <= '0;
            inflight_q  <= '0;
        end else begin
            stg_q[0] <= {accept, we, sel, addr, dat_i};
            for (int i = 1; i < NST; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
            acc_valid_q <= last.valid;
            acc_we_q    <= last.we;
            acc_oor_q   <= last_oor;
            ack_q       <= ack_d;
            err_q       <= err_d;
            dat_q       <= dat_d;
            inflight_q  <= inflight_d;
        end
    end

    // RAM has no reset; a cleared delay line guarantees no access during or after reset.
    always_ff @(posedge clk) begin
        if (last.valid && !last_oor) begin
            if (last.we) begin
                for (int b = 0; b < NB; b++) begin
                    if (last.sel[b]) begin
                        mem_q[last_idx][b*8 +: 8] <= last.data[b*8 +: 8];
                    end
                end
            end else begin
                rd_q <= mem_q[last_idx];
            end
        end
    end

    always_comb begin
        ack_d = acc_valid_q;
        err_d = acc_valid_q & acc_oor_q;
        dat_d = '0;
        if (acc_valid_q && !acc_we_q && !acc_oor_q) begin
            dat_d = rd_q;
        end
    end

    // The counter drops on the edge that raises ack, so stall releases with the first response.
    always_comb begin
        inflight_d = inflight_q;
        if (accept && !acc_valid_q) begin
            inflight_d = inflight_q + CW'(1);
        end else if (!accept && acc_valid_q) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign dat_o = dat_q;

endmodule

// File: tb/tb_exmem_pipeline_ctrl.sv
// tb/tb_exmem_pipeline_ctrl.sv - randomized self-checking bench for exmem_pipeline_ctrl
module tb_exmem_pipeline_ctrl;

    localparam int L     = 10;
    localparam int MO    = 4;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] dat_i = 32'h0;
    logic        stall, ack, err;
    logic [31:0] dat_o;

    always #5 clk = ~clk;

    exmem_pipeline_ctrl #(
        .DATA_W (32),
        .DEPTH  (DEPTH),
        .LATENCY(L),
        .MAX_OUT(MO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .stb   (stb),
        .we    (we),
        .sel   (sel),
        .addr  (addr),
        .dat_i (dat_i),
        .stall (stall),
        .ack   (ack),
        .err   (err),
        .dat_o (dat_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle", name, act, exp);
        end
    endtask

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    rsp_t        q[$];
    bit [31:0]   mem[int];
    int          inflight = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          acc_cyc = 0;
    logic        e_ack = 1'b0;
    logic        e_err = 1'b0;
    logic [31:0] e_dat = 32'h0;

    // Reference: responses computed at accept time in order, delivered L edges later.
    always @(posedge clk) begin
        bit        a;
        rsp_t      r;
        int        widx;
        bit [31:0] w;
        cyc++;
        e_ack = 1'b0;
        e_err = 1'b0;
        e_dat = 32'h0;
        if (!rst_n) begin
            q.delete();
            inflight = 0;
        end else begin
            a = stb && (inflight != MO);
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                e_ack = 1'b1;
                e_err = r.err;
                e_dat = r.dat;
                inflight--;
            end
            if (a) begin
                widx  = int'(addr >> 2);
                r.due = cyc + L;
                r.err = 1'b0;
                r.dat = 32'h0;
                if (widx >= DEPTH) begin
                    r.err = 1'b1;
                end else if (we) begin
                    w = mem.exists(widx) ? mem[widx] : 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (sel[b]) w[8*b +: 8] = dat_i[8*b +: 8];
                    end
                    mem[widx] = w;
                end else begin
                    r.dat = mem.exists(widx) ? mem[widx] : 32'h0;
                end
                q.push_back(r);
                inflight++;
                n_acc++;
                acc_cyc = cyc;
            end
        end
    end

    bit          chk_en = 1'b0;
    int          lg_cyc[$];
    logic [31:0] lg_dat[$];
    logic        lg_err[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("ack", ack, e_ack);
            check("err", err, e_err);
            check("dat_o", dat_o, e_dat);
            check("stall", stall, (inflight == MO));
            if (ack) begin
                lg_cyc.push_back(cyc);
                lg_dat.push_back(dat_o);
                lg_err.push_back(err);
            end
        end
    end

    task automatic req(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output int c);
        int start;
        start = n_acc;
        stb = 1'b1; we = w; sel = s; addr = a; dat_i = d;
        c = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (n_acc != start) begin
                c = acc_cyc;
                break;
            end
        end
        #1 stb = 1'b0;
        if (c < 0) check("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (q.size() == 0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (ok == 0) check("idle_timeout", 0, 1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, c, b;
        int ac[8];
        logic [31:0] ra;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_stall", stall, 0);
        check("reset_ack", ack, 0);
        check("reset_dat_o", dat_o, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1;

        b = lg_cyc.size();
        req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, c1);
        req(1'b0, 4'hF, 32'h10, 32'h0, c2);
        wait_idle();
        check("t1_ack_count", lg_cyc.size() - b, 2);
        check("t1_ack_latency", lg_cyc[b] - c1, 10);
        check("t1_err", lg_err[b], 0);
        check("t1_dat_o", lg_dat[b], 32'h0);
        check("t2_next_cycle", c2 - c1, 1);
        check("t2_ack_latency", lg_cyc[b+1] - c2, 10);
        check("t2_dat_o", lg_dat[b+1], 32'hDEADBEEF);

        for (int i = 0; i < 16; i++) req(1'b1, 4'hF, 32'(i * 4), $urandom, c);
        wait_idle();

        b = lg_cyc.size();
        req(1'b1, 4'hF, 32'h20, 32'hAAAAAAAA, c);
        req(1'b1, 4'b0101, 32'h20, 32'h11223344, c);
        req(1'b0, 4'hF, 32'h20, 32'h0, c);
        wait_idle();
        check("t3_merge", lg_dat[b+2], 32'hAA22AA44);

        b = lg_cyc.size();
        for (int i = 0; i < 8; i++) req(1'b0, 4'hF, 32'(i * 4), 32'h0, ac[i]);
        wait_idle();
        check("t4_first_four", ac[3] - ac[0], 3);
        check("t4_stall_release", ac[4] - ac[0], L + 1);
        check("t4_ack_count", lg_cyc.size() - b, 8);
        for (int i = 0; i < 8; i++) check("t4_ack_order", lg_cyc[b+i] - ac[i], L);

        b = lg_cyc.size();
        req(1'b0, 4'hF, 32'(DEPTH * 4), 32'h0, c);
        req(1'b1, 4'hF, 32'(DEPTH * 4), 32'hFFFFFFFF, c);
        wait_idle();
        check("t5_rd_err", lg_err[b], 1);
        check("t5_rd_dat", lg_dat[b], 32'h0);
        check("t5_wr_err", lg_err[b+1], 1);
        for (int i = 0; i < 16; i++) req(1'b0, 4'hF, 32'(i * 4), 32'h0, c);
        wait_idle();

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                #1;
            end
            case ($urandom_range(0, 9))
                0:       ra = 32'h1000 + 32'($urandom_range(0, 255) * 4);
                1:       ra = 32'h80000010;
                default: ra = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            endcase
            req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ra, $urandom, c);
        end
        wait_idle();

        for (int i = 0; i < 3; i++) req(1'b0, 4'hF, 32'(i * 4), 32'h0, c);
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        b = lg_cyc.size();
        repeat (20) @(negedge clk);
        #1;
        check("t6_no_acks", lg_cyc.size() - b, 0);
        check("t6_stall", stall, 0);
        req(1'b0, 4'hF, 32'h10, 32'h0, c);
        wait_idle();
        check("t6_ack_count", lg_cyc.size() - b, 1);
        check("t6_ack_latency", lg_cyc[b] - c, L);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
